// File: rtl/md_unit.sv
// md_unit: multiply/divide sequencer with HI/LO registers.
// The result is computed at the accepting edge, held in pending registers,
// and committed to HI/LO after a fixed latency while Busy stays high.
// Handshake: a request is taken only when Start=1 and the unit is idle
// (Busy=0); Start while Busy=1 is ignored, and upstream is expected to
// stall instead of issuing.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        o_dbg_run
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_div0;
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;
  logic [31:0]    r_phi;
  logic [31:0]    r_plo;

  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [31:0]        w_dvs_s;
  logic [31:0]        w_dvs_u;
  logic [31:0]        w_uq_s;
  logic [31:0]        w_ur_s;
  logic [31:0]        w_q_s;
  logic [31:0]        w_r_s;
  logic [31:0]        w_q_u;
  logic [31:0]        w_r_u;
  logic [31:0]        w_res_hi;
  logic [31:0]        w_res_lo;
  logic               w_b_zero;

  // Products and quotients, computed from the live operands so they can be
  // captured at the accepting edge. Signed divide works on magnitudes; this
  // also makes 0x80000000 / -1 come out as 0x80000000 rem 0 without overflow.
  always_comb begin
    w_prod_s = $signed(A) * $signed(B);
    w_prod_u = {32'd0, A} * {32'd0, B};
    w_b_zero = (B == 32'd0);
    w_a_neg  = A[31];
    w_b_neg  = B[31];
    w_a_mag  = w_a_neg ? (32'd0 - A) : A;
    w_b_mag  = w_b_neg ? (32'd0 - B) : B;
    // A zero divisor is replaced by one only to keep the divider defined;
    // the result is discarded at commit anyway.
    w_dvs_s  = w_b_zero ? 32'd1 : w_b_mag;
    w_dvs_u  = w_b_zero ? 32'd1 : B;
    w_uq_s   = w_a_mag / w_dvs_s;
    w_ur_s   = w_a_mag % w_dvs_s;
    w_q_s    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq_s) : w_uq_s;
    w_r_s    = w_a_neg ? (32'd0 - w_ur_s) : w_ur_s;
    w_q_u    = A / w_dvs_u;
    w_r_u    = A % w_dvs_u;
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (MDOp)
      OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      OP_DIV:   begin w_res_hi = w_r_s;           w_res_lo = w_q_s;          end
      OP_DIVU:  begin w_res_hi = w_r_u;           w_res_lo = w_q_u;          end
      default:  ;
    endcase
  end

  // Sequencer: accept in IDLE, count down in RUN, commit on the 1->0 edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_div0  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            case (MDOp)
              OP_MULT, OP_MULTU: begin
                r_phi   <= w_res_hi;
                r_plo   <= w_res_lo;
                r_div0  <= 1'b0;
                r_cnt   <= CW'(MULT_CYCLES);
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                r_phi   <= w_res_hi;
                r_plo   <= w_res_lo;
                r_div0  <= w_b_zero;
                r_cnt   <= CW'(DIV_CYCLES);
                r_state <= S_RUN;
                r_busy  <= 1'b1;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            if (!r_div0) begin
              r_hi <= r_phi;
              r_lo <= r_plo;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy      = r_busy;
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign o_dbg_run = (r_state == S_RUN);

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random traffic, compared each cycle
// against an arithmetic reference model of HI/LO/Busy.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        dbg_run;

  int n_checks = 0;
  int n_errors = 0;
  int n_proto  = 0;

  // reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;
  bit          m_div0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .Busy(Busy), .HI(HI), .LO(LO), .o_dbg_run(dbg_run)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0; m_div0 = 0;
  endtask

  // One clock edge of architectural behaviour, from the instruction rules.
  task automatic model_step(input logic st, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned ua, up;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_div0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (st) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      case (op)
        3'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; m_div0 = 0; m_left = MC; end
        3'd2: begin up = ua * {32'd0, b}; m_phi = up[63:32]; m_plo = up[31:0]; m_div0 = 0; m_left = MC; end
        3'd3: begin
          m_left = DC;
          m_div0 = (b == 0);
          if (b != 0) begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
        end
        3'd4: begin
          m_left = DC;
          m_div0 = (b == 0);
          if (b != 0) begin m_plo = a / b; m_phi = a % b; end
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // driver: present inputs for one cycle, step the model, compare
  task automatic cycle(input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = st; MDOp = op; A = a; B = b;
    if (st && m_left > 0) begin
      n_proto++;
      $display("note: protocol violation, Start while busy at %0t", $time);
    end
    @(posedge clk);
    model_step(st, op, a, b);
    #1;
    check("busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
    check("dbg_run", {31'd0, dbg_run}, {31'd0, (m_left > 0)});
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
  endtask

  task automatic idle();
    cycle(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  // issue an op, then run idle cycles until Busy drops; returns Busy cycles
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int n_busy);
    int guard;
    n_busy = 0;
    guard  = 0;
    cycle(1'b1, op, a, b);
    if (Busy) n_busy++;
    while (Busy && guard < 40) begin
      idle();
      if (Busy) n_busy++;
      guard++;
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    reset = 1'b0; Start = 1'b0; MDOp = 3'd0; A = 0; B = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_busy", {31'd0, Busy}, 32'd0);
    check("init_hi", HI, 32'd0);
    check("init_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(); idle();

    // mult / multu
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, nb);
    check("mult_busy_len", nb, MC);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, nb);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    // div / divu
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, nb);
    check("div_busy_len", nb, DC);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd7, 32'd2, nb);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);

    // boundary divides
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'd0);
    cycle(1'b1, 3'd5, 32'h1234, 32'd0);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    cycle(1'b1, 3'd6, 32'h5678, 32'd0);
    run_op(3'd3, 32'd99, 32'd0, nb);
    check("div0_busy_len", nb, DC);
    check("div0_hi", HI, 32'h1234);
    check("div0_lo", LO, 32'h5678);
    run_op(3'd4, 32'd99, 32'd0, nb);
    check("divu0_lo", LO, 32'h5678);

    // Start during RUN is ignored; next op right after Busy falls is taken
    cycle(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
    idle();
    cycle(1'b1, 3'd6, 32'hDEAD, 32'd0);
    while (Busy) idle();
    check("ignored_mtlo_lo", LO, 32'hFFFF_FFFA);
    cycle(1'b1, 3'd4, 32'd100, 32'd7);
    check("b2b_busy", {31'd0, Busy}, 32'd1);
    while (Busy) idle();
    check("b2b_lo", LO, 32'd14);
    check("b2b_hi", HI, 32'd2);

    // reset mid-RUN
    cycle(1'b1, 3'd1, 32'd1000, 32'd1000);
    idle(); idle();
    async_reset();
    cycle(1'b1, 3'd5, 32'hA5A5_A5A5, 32'd0);
    check("post_rst_hi", HI, 32'hA5A5_A5A5);
    check("post_rst_busy", {31'd0, Busy}, 32'd0);
    idle();

    // random traffic, Start only when the model says idle
    for (int i = 0; i < 600; i++) begin
      if (m_left == 0 && $urandom_range(0, 9) < 7)
        cycle(1'b1, 3'($urandom_range(0, 7)), rand_operand(), rand_operand());
      else
        idle();
    end
    while (m_left > 0) idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide sequencer for the E stage of the pipelined MIPS core, sitting beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo requests and computes multi-cycle products and quotients. It holds the HI/LO architectural registers and raises Busy while an operation is in flight, so the hazard unit can stall any later mult/div/mfhi/mflo/mthi/mtlo.

## Interface
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (>=1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (>=1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- Start  in  1  E-stage instruction is an MD op this cycle
- MDOp  in  3  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; others reserved
- A  in  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- B  in  32  rt operand (divisor / multiplier)
- Busy  out  1  operation in flight
- HI  out  32  HI register (mfhi source)
- LO  out  32  LO register (mflo source)

## Operation
- States: IDLE, RUN; down-counter cnt (4 bits min, sized for max(MULT_CYCLES, DIV_CYCLES)).
- IDLE, Start=1, MDOp in 1..4:
  - compute result into pending regs pHI/pLO at that edge;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, Start=1, MDOp=5: HI<=A. MDOp=6: LO<=A. Both take effect at that edge; no RUN.
- IDLE, Start=1, MDOp reserved (0, 7): no state change.
- RUN: cnt decrements each edge. On the edge where cnt goes 1->0: HI<=pHI, LO<=pLO, go to IDLE.
- Start=1 while in RUN: ignored entirely. The hazard unit guarantees this never happens; the bench flags it as a protocol error.
- mult: {HI,LO} = signed A * signed B, 64-bit. multu: unsigned.
- div: LO = quotient truncated toward zero; HI = remainder with sign of dividend.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divisor B=0 (div/divu): full RUN latency still taken; HI and LO left unchanged at commit.
- Busy = (state==RUN); registered, no combinational path from Start.
- HI/LO hold their value throughout RUN; mfhi/mflo during RUN are stalled upstream, never served stale here.

## Timing
- Reset (async assert): state=IDLE, cnt=0, Busy=0, HI=0, LO=0, pHI=pLO=0. Outputs change without waiting for clk.
- Reset mid-RUN: operation aborted; pending result discarded; after deassert, first Start is accepted normally.
- Start accepted at edge k: Busy=1 from edge k through edge k+N-1 (N cycles high, N = MULT_CYCLES or DIV_CYCLES).
- Same start at edge k: HI/LO update at edge k+N, Busy=0 at edge k+N.
- Back-to-back: new Start presented in the cycle after Busy falls is accepted (zero bubble).
- mthi/mtlo: HI/LO visible the cycle after the edge; Busy never rises.
- A/B are sampled only at the accepting edge; later changes during RUN have no effect.

## Test plan
- Reset, then hold reset=1 idle -> Busy=0, HI=LO=0. Assert reset low asynchronously between edges -> outputs 0 immediately.
- mult A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- Boundary divides:
  - div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - div with B=0 after mthi 0x1234 / mtlo 0x5678 -> HI=0x1234, LO=0x5678 after 10 Busy cycles.
- Issue mult, pulse Start with mtlo A=0xDEAD at cycle 2 of RUN -> ignored (LO = product, not 0xDEAD). Then issue div the cycle Busy falls -> accepted, Busy rises the next edge.
- Start mult, assert reset at cycle 3 of RUN -> Busy=0, HI=LO=0 immediately. After release, mthi A=0xA5A5A5A5 -> HI=0xA5A5A5A5 next cycle, Busy stays 0.
